// File: rtl/bfly_operand_aligner_if.sv
// ----------------------------------------------------------------------------
// bfly_operand_aligner_if
//   Bundle of every signal exchanged between the FFT butterfly operand/result
//   aligner and its surroundings: the upstream operand stream, the butterfly
//   core, the downstream result stream and the status outputs.
//
//   master : the environment (operand source, butterfly core, result sink)
//   slave  : the aligner itself
//
//   Upstream  : in_valid/in_ready handshake, mode_req/mode_cur, a/b/tw operands
//   Core side : core_start, core_use_ct, aligned core_a/b/tw,
//               core_done plus core_ao/core_bo results
//   Result    : out_valid, aligned ao/bo
//   Status    : inflight count, sticky err
// ----------------------------------------------------------------------------
interface bfly_operand_aligner_if #(
   parameter int BITWIDTH     = 64,
   parameter int LANES        = 1,
   parameter int MAX_INFLIGHT = 32
);
   localparam int W     = LANES * BITWIDTH;
   localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

   logic             in_valid;
   logic             in_ready;
   logic             mode_req;
   logic             mode_cur;
   logic [W-1:0]     a_re, a_im, b_re, b_im, tw_re, tw_im;

   logic             core_start;
   logic             core_use_ct;
   logic [W-1:0]     core_a_re, core_a_im, core_b_re, core_b_im, core_tw_re, core_tw_im;
   logic             core_done;
   logic [W-1:0]     core_ao_re, core_ao_im, core_bo_re, core_bo_im;

   logic             out_valid;
   logic [W-1:0]     ao_re, ao_im, bo_re, bo_im;
   logic [CNT_W-1:0] inflight;
   logic             err;

   modport master (
      output in_valid, mode_req, a_re, a_im, b_re, b_im, tw_re, tw_im,
      output core_done, core_ao_re, core_ao_im, core_bo_re, core_bo_im,
      input  in_ready, mode_cur,
      input  core_start, core_use_ct,
      input  core_a_re, core_a_im, core_b_re, core_b_im, core_tw_re, core_tw_im,
      input  out_valid, ao_re, ao_im, bo_re, bo_im, inflight, err
   );

   modport slave (
      input  in_valid, mode_req, a_re, a_im, b_re, b_im, tw_re, tw_im,
      input  core_done, core_ao_re, core_ao_im, core_bo_re, core_bo_im,
      output in_ready, mode_cur,
      output core_start, core_use_ct,
      output core_a_re, core_a_im, core_b_re, core_b_im, core_tw_re, core_tw_im,
      output out_valid, ao_re, ao_im, bo_re, bo_im, inflight, err
   );
endinterface

// File: rtl/bfly_operand_aligner.sv
// ----------------------------------------------------------------------------
// bfly_operand_aligner
//   Operand/result alignment front-end for the FFT butterfly core.
//   - Accepts one butterfly per cycle (in_valid & in_ready) and fires
//     core_start in the same cycle with b passed straight through.
//   - a and twiddle travel through free-running delay lines; the tap used
//     depends on the applied mode (CT: a +CMULT_DELAY+2, tw +1;
//     GS: a +1, tw +ADD_DELAY+2).
//   - In GS mode the core's a result is delayed by CMULT_DELAY+1 so that it
//     lines up with core_done; b results always pass straight through.
//   - Counts outstanding butterflies and raises a sticky err on a core_done
//     that has no matching operation.
//   - A change of mode_req drains the pipeline before mode_cur is switched;
//     a request that reverts before the drain completes is ignored.
//
// Ports
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : bfly_operand_aligner_if.slave (all data/handshake/status signals)
// ----------------------------------------------------------------------------
module bfly_operand_aligner #(
   parameter int BITWIDTH      = 64,
   parameter int LANES         = 1,
   parameter int ADD_DELAY     = 3,
   parameter int CMULT_DELAY   = 6,
   parameter int MAX_INFLIGHT  = 32,
   parameter bit RESET_MODE_CT = 1'b0
) (
   input  logic                   clk,
   input  logic                   rst,
   bfly_operand_aligner_if.slave  bus
);
   localparam int W      = LANES * BITWIDTH;
   localparam int CNT_W  = $clog2(MAX_INFLIGHT + 1);
   localparam int A_LEN  = CMULT_DELAY + 2;   // longest a delay (CT)
   localparam int TW_LEN = ADD_DELAY + 2;     // longest tw delay (GS)
   localparam int AO_LEN = CMULT_DELAY + 1;   // GS result realignment

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_DRAIN,
      ST_SWITCH
   } state_t;

   state_t           state_q, state_d;
   logic             mode_q;
   logic [CNT_W-1:0] inflight_q;
   logic             err_q;
   logic             in_ready;
   logic             accept;
   logic             mode_match;

   // Each entry holds {im, re} of one operand; entry i is delayed i+1 cycles.
   logic [2*W-1:0]   a_sr  [A_LEN];
   logic [2*W-1:0]   tw_sr [TW_LEN];
   logic [2*W-1:0]   ao_sr [AO_LEN];
   logic [2*W-1:0]   a_tap, tw_tap, ao_sel;

   assign mode_match = (bus.mode_req == mode_q);
   assign accept     = bus.in_valid & in_ready;

   // -------------------------------------------------------------------------
   // Free-running delay lines (shift every cycle, independent of accept)
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: these few registers drive the core directly, so they are
         // cleared on reset; a deep RAM-style delay line would be left unreset.
         for (int i = 0; i < A_LEN; i++)  a_sr[i]  <= '0;
         for (int i = 0; i < TW_LEN; i++) tw_sr[i] <= '0;
         for (int i = 0; i < AO_LEN; i++) ao_sr[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments make every stage sample the previous
         // stage's old value, which is exactly what a shift register needs.
         a_sr[0]  <= {bus.a_im, bus.a_re};
         tw_sr[0] <= {bus.tw_im, bus.tw_re};
         ao_sr[0] <= {bus.core_ao_im, bus.core_ao_re};
         for (int i = 1; i < A_LEN; i++)  a_sr[i]  <= a_sr[i-1];
         for (int i = 1; i < TW_LEN; i++) tw_sr[i] <= tw_sr[i-1];
         for (int i = 1; i < AO_LEN; i++) ao_sr[i] <= ao_sr[i-1];
      end
   end

   assign a_tap  = mode_q ? a_sr[CMULT_DELAY+1] : a_sr[0];
   assign tw_tap = mode_q ? tw_sr[0]            : tw_sr[ADD_DELAY+1];
   assign ao_sel = mode_q ? {bus.core_ao_im, bus.core_ao_re} : ao_sr[AO_LEN-1];

   // -------------------------------------------------------------------------
   // In-flight counter and sticky error
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         inflight_q <= '0;
         err_q      <= 1'b0;
      end else begin
         if (bus.core_done && (inflight_q == '0)) err_q <= 1'b1;
         unique case ({accept, bus.core_done})
            2'b10:   inflight_q <= inflight_q + CNT_ONE;
            // An unmatched core_done leaves the counter parked at zero.
            2'b01:   if (inflight_q != '0) inflight_q <= inflight_q - CNT_ONE;
            default: ;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Mode-switch FSM
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         mode_q  <= RESET_MODE_CT;
      end else begin
         state_q <= state_d;
         if (state_q == ST_SWITCH) mode_q <= bus.mode_req;
      end
   end

   always_comb begin
      // NOTE: defaults first so every path assigns both outputs (no latches).
      state_d  = state_q;
      in_ready = 1'b0;
      unique case (state_q)
         ST_RUN: begin
            in_ready = mode_match && (inflight_q < MAX_CNT);
            if (!mode_match) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            // A reverted request cancels the drain without touching mode_cur.
            if (mode_match)              state_d = ST_RUN;
            else if (inflight_q == '0)   state_d = ST_SWITCH;
         end
         ST_SWITCH: state_d = ST_RUN;
         default:   state_d = ST_RUN;
      endcase
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign bus.in_ready    = in_ready;
   assign bus.mode_cur    = mode_q;
   assign bus.core_use_ct = mode_q;
   assign bus.core_start  = accept;

   assign bus.core_b_re   = bus.b_re;
   assign bus.core_b_im   = bus.b_im;
   assign {bus.core_a_im, bus.core_a_re}   = a_tap;
   assign {bus.core_tw_im, bus.core_tw_re} = tw_tap;

   assign bus.out_valid   = bus.core_done;
   assign {bus.ao_im, bus.ao_re} = ao_sel;
   assign bus.bo_re       = bus.core_bo_re;
   assign bus.bo_im       = bus.core_bo_im;

   assign bus.inflight    = inflight_q;
   assign bus.err         = err_q;
endmodule
